// File: rtl/cpu_pkg.sv
// Shared CPU bus definitions: widths, bus FSM encodings, requester/grant codes.
package cpu_pkg;
   localparam int CPU_BITS = 8;
   localparam int STATE_W  = 2;

   typedef enum logic [STATE_W-1:0] {
      BUS_IDLE = 2'd0,
      BUS_ADDR = 2'd1,
      BUS_WAIT = 2'd2,
      BUS_DATA = 2'd3
   } bus_state_t;

   typedef enum logic {
      FETCH_ROM = 1'b0,
      FETCH_RAM = 1'b1
   } src_t;

   // Also used as bit positions in the one-hot grant vector.
   typedef enum logic {
      GRANT_IF  = 1'b0,
      GRANT_MEM = 1'b1
   } grant_t;
endpackage

// File: rtl/bus_sequencer_if.sv
// Requester handshakes plus external bus pins of the shared bus sequencer.
interface bus_sequencer_if #(parameter int BITS = 8);
   logic            if_req;
   logic [BITS-1:0] if_addr;
   logic            if_done;
   logic [BITS-1:0] if_rdata;
   logic            mem_req;
   logic            mem_we;
   logic [BITS-1:0] mem_addr;
   logic [BITS-1:0] mem_wdata;
   logic            mem_done;
   logic [BITS-1:0] mem_rdata;
   logic [BITS-1:0] bus_in;
   logic [BITS-1:0] bus_out;
   logic            rom_ram;
   logic            addr_data;
   logic            bus_we;
   logic            busy;

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, bus_in,
      input  if_done, if_rdata, mem_done, mem_rdata, bus_out, rom_ram, addr_data, bus_we, busy
   );

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, bus_in,
      output if_done, if_rdata, mem_done, mem_rdata, bus_out, rom_ram, addr_data, bus_we, busy
   );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way arbiter (fetch vs mem): alternating or mem-priority on conflict, one-hot grant.
module rr_arbiter2
   import cpu_pkg::*;
#(
   parameter int FAIR = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_if,
   input  logic       req_mem,
   input  logic       en,
   output logic [1:0] grant
);
   grant_t last_grant;

   always_comb begin
      grant = '0;
      if (req_if && req_mem) begin
         if ((FAIR != 0) && (last_grant == GRANT_MEM)) grant[GRANT_IF] = 1'b1;
         else                                          grant[GRANT_MEM] = 1'b1;
      end else if (req_if) begin
         grant[GRANT_IF] = 1'b1;
      end else if (req_mem) begin
         grant[GRANT_MEM] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)                last_grant <= GRANT_MEM;
      else if (en && (|grant))  last_grant <= grant[GRANT_MEM] ? GRANT_MEM : GRANT_IF;
   end
endmodule

// File: rtl/bus_sequencer.sv
// Arbitrates fetch and mem requesters onto the shared multiplexed bus and sequences
// ADDR -> WAIT x WAIT_CYCLES -> DATA, then pulses the winner's done for one cycle.
module bus_sequencer
   import cpu_pkg::*;
#(
   parameter int BITS        = CPU_BITS,
   parameter int WAIT_CYCLES = 1,
   parameter int FAIR        = 1
) (
   input  logic            clk,
   input  logic            reset,
   bus_sequencer_if.slave  bus
);
   localparam logic [1:0] WAIT_LAST = 2'(WAIT_CYCLES - 1);

   bus_state_t      state;
   logic [1:0]      wait_cnt;
   logic [BITS-1:0] addr_q;
   logic [BITS-1:0] wdata_q;
   logic            we_q;
   src_t            src_q;
   logic            if_done_q;
   logic            mem_done_q;
   logic [BITS-1:0] if_rdata_q;
   logic [BITS-1:0] mem_rdata_q;
   logic [1:0]      grant;
   logic            sample_en;

   // Skipping the done cycle lets a requester update or drop req before resampling.
   assign sample_en = (state == BUS_IDLE) && !if_done_q && !mem_done_q;

   rr_arbiter2 #(.FAIR(FAIR)) u_arb (
      .clk     (clk),
      .reset   (reset),
      .req_if  (bus.if_req),
      .req_mem (bus.mem_req),
      .en      (sample_en),
      .grant   (grant)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= BUS_IDLE;
         wait_cnt    <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         src_q       <= FETCH_ROM;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         if_done_q  <= 1'b0;
         mem_done_q <= 1'b0;
         case (state)
            BUS_IDLE: begin
               if (sample_en && grant[GRANT_MEM]) begin
                  addr_q  <= bus.mem_addr;
                  wdata_q <= bus.mem_wdata;
                  we_q    <= bus.mem_we;
                  src_q   <= FETCH_RAM;
                  state   <= BUS_ADDR;
               end else if (sample_en && grant[GRANT_IF]) begin
                  addr_q  <= bus.if_addr;
                  wdata_q <= '0;
                  we_q    <= 1'b0;
                  src_q   <= FETCH_ROM;
                  state   <= BUS_ADDR;
               end
            end
            BUS_ADDR: begin
               wait_cnt <= '0;
               state    <= (WAIT_CYCLES > 0) ? BUS_WAIT : BUS_DATA;
            end
            BUS_WAIT: begin
               if (wait_cnt == WAIT_LAST) state <= BUS_DATA;
               else                       wait_cnt <= wait_cnt + 2'd1;
            end
            BUS_DATA: begin
               if (!we_q) begin
                  if (src_q == FETCH_ROM) if_rdata_q  <= bus.bus_in;
                  else                    mem_rdata_q <= bus.bus_in;
               end
               if_done_q  <= (src_q == FETCH_ROM);
               mem_done_q <= (src_q == FETCH_RAM);
               state      <= BUS_IDLE;
            end
            default: state <= BUS_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.bus_out = '0;
      case (state)
         BUS_ADDR:           bus.bus_out = addr_q;
         BUS_WAIT, BUS_DATA: bus.bus_out = we_q ? wdata_q : '0;
         default:            bus.bus_out = '0;
      endcase
   end

   assign bus.addr_data = (state == BUS_WAIT) || (state == BUS_DATA);
   assign bus.rom_ram   = (state != BUS_IDLE) && (src_q == FETCH_RAM);
   assign bus.bus_we    = (state == BUS_DATA) && we_q;
   assign bus.busy      = (state != BUS_IDLE);
   assign bus.if_done   = if_done_q;
   assign bus.mem_done  = mem_done_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.mem_rdata = mem_rdata_q;
endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench: three sequencers (W1/fair, W0/fair, W1/mem-priority) on one clock.
module tb_bus_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   bus_sequencer_if #(.BITS(8)) ia ();
   bus_sequencer_if #(.BITS(8)) ib ();
   bus_sequencer_if #(.BITS(8)) ic ();

   bus_sequencer #(.BITS(8), .WAIT_CYCLES(1), .FAIR(1)) dut_a (.clk(clk), .reset(reset), .bus(ia));
   bus_sequencer #(.BITS(8), .WAIT_CYCLES(0), .FAIR(1)) dut_b (.clk(clk), .reset(reset), .bus(ib));
   bus_sequencer #(.BITS(8), .WAIT_CYCLES(1), .FAIR(0)) dut_c (.clk(clk), .reset(reset), .bus(ic));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      ia.if_req = 0; ia.mem_req = 0; ia.mem_we = 0;
      ib.if_req = 0; ib.mem_req = 0; ib.mem_we = 0;
      ic.if_req = 0; ic.mem_req = 0; ic.mem_we = 0;
   endtask

   initial begin
      logic [7:0] a_grants [4];
      logic [7:0] c_grants [4];
      int         na, nc;
      int         addr_cyc [3];
      logic [7:0] addr_val [3];
      int         done_cyc [3];
      int         nad, nd;
      bit         found;

      clear_reqs();
      ia.if_addr = 0; ia.mem_addr = 0; ia.mem_wdata = 0; ia.bus_in = 0;
      ib.if_addr = 0; ib.mem_addr = 0; ib.mem_wdata = 0; ib.bus_in = 0;
      ic.if_addr = 0; ic.mem_addr = 0; ic.mem_wdata = 0; ic.bus_in = 0;
      tick(); tick();
      check("rst_busy", ia.busy, 0);
      check("rst_bus_out", ia.bus_out, 0);
      check("rst_addr_data", ia.addr_data, 0);
      check("rst_rom_ram", ia.rom_ram, 0);
      check("rst_done", {ia.if_done, ia.mem_done}, 0);
      check("rst_rdata", {ia.if_rdata, ia.mem_rdata}, 0);
      reset = 0;

      // Fetch read, one wait cycle
      ia.if_req = 1; ia.if_addr = 8'h10;
      tick();
      check("f_addr_phase", {ia.busy, ia.addr_data, ia.rom_ram, ia.bus_out}, {3'b100, 8'h10});
      tick();
      check("f_wait_phase", {ia.addr_data, ia.rom_ram, ia.bus_out}, {2'b10, 8'h00});
      ia.bus_in = 8'hA5;
      tick();
      check("f_data_phase", {ia.addr_data, ia.bus_we, ia.bus_out}, {2'b10, 8'h00});
      check("f_no_early_done", ia.if_done, 0);
      tick();
      check("f_done", {ia.if_done, ia.mem_done, ia.busy}, 3'b100);
      check("f_rdata", ia.if_rdata, 8'hA5);
      ia.if_req = 0;
      tick();
      check("f_done_pulse_end", {ia.if_done, ia.busy}, 0);

      // Mem write, one wait cycle
      ia.mem_req = 1; ia.mem_we = 1; ia.mem_addr = 8'h20; ia.mem_wdata = 8'h3C;
      tick();
      check("w_addr_phase", {ia.addr_data, ia.rom_ram, ia.bus_we, ia.bus_out}, {3'b010, 8'h20});
      tick();
      check("w_wait_phase", {ia.addr_data, ia.rom_ram, ia.bus_we, ia.bus_out}, {3'b110, 8'h3C});
      tick();
      check("w_data_phase", {ia.addr_data, ia.rom_ram, ia.bus_we, ia.bus_out}, {3'b111, 8'h3C});
      tick();
      check("w_done", {ia.mem_done, ia.if_done, ia.bus_we}, 3'b100);
      check("w_rdata_kept", ia.mem_rdata, 8'h00);
      clear_reqs();
      tick(); tick();

      // Conflict arbitration from reset: fair vs mem-priority
      reset = 1;
      ia.if_req = 1; ia.mem_req = 1; ia.if_addr = 8'h01; ia.mem_addr = 8'h02;
      ic.if_req = 1; ic.mem_req = 1; ic.if_addr = 8'h01; ic.mem_addr = 8'h02;
      tick(); tick();
      reset = 0;
      na = 0; nc = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ia.busy && !ia.addr_data && na < 4) begin a_grants[na] = {7'd0, ia.rom_ram}; na++; end
         if (ic.busy && !ic.addr_data && nc < 4) begin c_grants[nc] = {7'd0, ic.rom_ram}; nc++; end
      end
      check("fair_count", na, 4);
      check("prio_count", nc, 4);
      for (int i = 0; i < 4; i++) begin
         if (i < na) check($sformatf("fair_grant%0d", i), a_grants[i], (i % 2 == 0) ? 0 : 1);
         if (i < nc) check($sformatf("prio_grant%0d", i), c_grants[i], 1);
      end
      ic.mem_req = 0;
      found = 0;
      for (int i = 0; i < 6 && !found; i++) begin
         tick();
         if (ic.busy && !ic.addr_data) begin
            found = 1;
            check("prio_fetch_when_idle", {ic.rom_ram, ic.bus_out}, {1'b0, 8'h01});
         end
      end
      if (!found) check("prio_fetch_found", 0, 1);
      clear_reqs();
      for (int i = 0; i < 8; i++) tick();

      // Back-to-back fetches with no wait state
      ib.if_req = 1; ib.if_addr = 8'h40; ib.bus_in = 8'hC3;
      nad = 0; nd = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (ib.busy && !ib.addr_data && nad < 3) begin
            addr_cyc[nad] = i; addr_val[nad] = ib.bus_out; nad++;
         end
         if (ib.if_done) begin
            if (nd < 3) begin done_cyc[nd] = i; nd++; end
            ib.if_addr = ib.if_addr + 8'd1;
         end
      end
      check("b2b_addr_count", nad, 3);
      check("b2b_done_count", nd, 3);
      for (int k = 0; k < 3; k++) begin
         if (k < nad) check($sformatf("b2b_addr%0d", k), addr_val[k], 8'h40 + k);
         if (k < nad) check($sformatf("b2b_start%0d", k), addr_cyc[k], 1 + 4 * k);
         if (k < nd) check($sformatf("b2b_done%0d", k), done_cyc[k], 3 + 4 * k);
      end
      check("b2b_rdata", ib.if_rdata, 8'hC3);
      clear_reqs();
      for (int i = 0; i < 4; i++) tick();

      // Reset during the DATA cycle of a fetch
      ia.if_req = 1; ia.if_addr = 8'h55; ia.bus_in = 8'h77;
      tick(); tick(); tick();
      check("rm_in_data", {ia.busy, ia.addr_data}, 2'b11);
      reset = 1;
      tick();
      check("rm_outputs_zero", {ia.busy, ia.addr_data, ia.rom_ram, ia.bus_we, ia.bus_out}, 0);
      check("rm_no_done", {ia.if_done, ia.mem_done}, 0);
      reset = 0;
      tick();
      check("rm_regrant", {ia.busy, ia.addr_data, ia.rom_ram, ia.bus_out}, {3'b100, 8'h55});
      tick(); tick(); tick();
      check("rm_done", {ia.if_done, ia.if_rdata}, {1'b1, 8'h77});
      clear_reqs();
      tick(); tick();

      // Mem request arriving mid-fetch waits for the fetch
      ia.if_req = 1; ia.if_addr = 8'h66; ia.bus_in = 8'h11;
      tick();
      ia.mem_req = 1; ia.mem_we = 0; ia.mem_addr = 8'h99;
      tick();
      check("np_still_fetch", {ia.busy, ia.rom_ram}, 2'b10);
      tick();
      tick();
      check("np_fetch_done", {ia.if_done, ia.mem_done, ia.busy}, 3'b100);
      check("np_fetch_rdata", ia.if_rdata, 8'h11);
      ia.if_req = 0;
      tick();
      check("np_done_cycle_idle", ia.busy, 0);
      tick();
      check("np_mem_grant", {ia.busy, ia.addr_data, ia.rom_ram, ia.bus_out}, {3'b101, 8'h99});
      ia.bus_in = 8'h5A;
      tick(); tick(); tick();
      check("np_mem_done", {ia.mem_done, ia.mem_rdata}, {1'b1, 8'h5A});
      check("np_if_rdata_kept", ia.if_rdata, 8'h11);
      clear_reqs();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
